pipe_write_tracker: RTL

- Producer side of the register-write/branch status bus that the decode-stage hazard detector consumes.
- Records destination register, write-enable and branch flag of each instruction leaving fetch.
- Advances these records through D/X/M/W in lock-step with the pipeline, handling freeze, flush and halt.
- Presents per-stage status plus a per-register busy mask, so that hazard stall decisions come from one authoritative copy of in-flight writes.

---
 rtl/pipe_write_tracker_pkg.sv | 36 +++
 rtl/pipe_track_stage.sv | 32 +++
 rtl/pipe_write_tracker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_write_tracker_pkg.sv
// Shared definitions for the pipeline write tracker.
// Holds the register-specifier constants, the per-stage entry record and its
// all-zero bubble value, and the index of each tracked stage (D/X/M/W).
package pipe_write_tracker_pkg;

    localparam int REG_BITS = 3;
    localparam int NUM_REGS = 8;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                valid;
        logic                regwrt;
        logic [REG_BITS-1:0] wrtreg;
        logic                branch;
        logic                halt;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '{
        valid:  1'b0,
        regwrt: 1'b0,
        wrtreg: {REG_BITS{1'b0}},
        branch: 1'b0,
        halt:   1'b0
    };

    localparam logic [1:0] STAGE_D = 2'd0;
    localparam logic [1:0] STAGE_X = 2'd1;
    localparam logic [1:0] STAGE_M = 2'd2;
    localparam logic [1:0] STAGE_W = 2'd3;

    // A stage blocks further issue only while it holds a live HALT.
    function automatic logic entry_is_halt(input stage_entry_t entry);
        return entry.valid & entry.halt;
    endfunction

endpackage

// File: rtl/pipe_track_stage.sv
// Single pipeline-stage entry register of the write tracker.
// Ports:
//   clk, rst     - clock and asynchronous active-low reset
//   clear_s      - load a bubble (takes priority over load_s)
//   load_s       - load entry_in_s
//   entry_in_s   - entry arriving from the previous stage / issue
//   entry_r      - registered entry of this stage
module pipe_track_stage
    import pipe_write_tracker_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_s,
    input  logic         load_s,
    input  stage_entry_t entry_in_s,
    output stage_entry_t entry_r
);

    // Entry register: squash beats advance, otherwise the entry holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_r <= BUBBLE;
        end else if (clear_s) begin
            entry_r <= BUBBLE;
        end else if (load_s) begin
            entry_r <= entry_in_s;
        end else begin
            entry_r <= entry_r;
        end
    end

endmodule

// File: rtl/pipe_write_tracker.sv
// Producer of the register-write / branch status bus for the decode-stage
// hazard detector. Tracks each instruction leaving fetch through D/X/M/W in
// lock-step with the pipeline, honouring freeze, flush and HALT.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   iss_*                    - instruction leaving fetch this cycle
//   freeze                   - whole pipeline held
//   flush                    - control transfer resolved in X
//   regWrt*/wrtReg*/branchInst* (D/X/M/W) - per-stage status, valid-gated
//   busy_mask                - registers with a pending write
//   inflight                 - number of valid entries in D..W
//   halted                   - sticky, HALT has reached W
// The stage record width follows the package REG_BITS; the REG_BITS and
// NUM_REGS parameters must be left at the package values.
module pipe_write_tracker #(
    parameter int REG_BITS    = pipe_write_tracker_pkg::REG_BITS,
    parameter int NUM_REGS    = pipe_write_tracker_pkg::NUM_REGS,
    parameter int BUSY_INCL_W = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic                iss_regwrt,
    input  logic [REG_BITS-1:0] iss_wrtreg,
    input  logic                iss_branch,
    input  logic                iss_halt,
    input  logic                freeze,
    input  logic                flush,
    output logic                regWrtD,
    output logic                regWrtX,
    output logic                regWrtM,
    output logic                regWrtW,
    output logic [REG_BITS-1:0] wrtRegD,
    output logic [REG_BITS-1:0] wrtRegX,
    output logic [REG_BITS-1:0] wrtRegM,
    output logic [REG_BITS-1:0] wrtRegW,
    output logic                branchInstD,
    output logic                branchInstX,
    output logic                branchInstM,
    output logic                branchInstW,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [2:0]          inflight,
    output logic                halted
);

    import pipe_write_tracker_pkg::*;

    stage_entry_t stage_r    [4];
    stage_entry_t stage_in_s [4];
    logic         load_s     [4];
    logic         clear_s    [4];

    stage_entry_t issue_s;
    logic         flush_eff_s;
    logic         halt_block_s;
    logic         flush_pend_r;
    logic         halted_r;
    logic [NUM_REGS-1:0] busy_s;
    logic [2:0]          inflight_s;

    // One-hot of the destination of an entry that really writes a register.
    function automatic logic [NUM_REGS-1:0] write_onehot(input stage_entry_t entry);
        logic [NUM_REGS-1:0] onehot;
        if (entry.valid & entry.regwrt) begin
            onehot = NUM_REGS'(1) << entry.wrtreg;
        end else begin
            onehot = {NUM_REGS{1'b0}};
        end
        return onehot;
    endfunction

    // A flush seen while frozen is remembered and applied on the first free edge.
    assign flush_eff_s  = (flush | flush_pend_r) & ~freeze;

    // W is deliberately excluded: a HALT in W no longer blocks issue.
    assign halt_block_s = entry_is_halt(stage_r[STAGE_D]) |
                          entry_is_halt(stage_r[STAGE_X]) |
                          entry_is_halt(stage_r[STAGE_M]);

    // Issue entry: bubble when nothing issues or a HALT is still ahead of W.
    always_comb begin
        issue_s = BUBBLE;
        if (iss_valid & ~halt_block_s) begin
            issue_s.valid  = 1'b1;
            issue_s.regwrt = iss_regwrt;
            issue_s.wrtreg = iss_wrtreg;
            issue_s.branch = iss_branch;
            issue_s.halt   = iss_halt;
        end else begin
            issue_s = BUBBLE;
        end
    end

    // Stage advance controls: D and X are squashed on flush, M and W always
    // advance so the resolving instruction survives.
    always_comb begin
        stage_in_s[STAGE_D] = issue_s;
        stage_in_s[STAGE_X] = stage_r[STAGE_D];
        stage_in_s[STAGE_M] = stage_r[STAGE_X];
        stage_in_s[STAGE_W] = stage_r[STAGE_M];
        load_s[STAGE_D]     = ~freeze & ~flush_eff_s;
        load_s[STAGE_X]     = ~freeze & ~flush_eff_s;
        load_s[STAGE_M]     = ~freeze;
        load_s[STAGE_W]     = ~freeze;
        clear_s[STAGE_D]    = flush_eff_s;
        clear_s[STAGE_X]    = flush_eff_s;
        clear_s[STAGE_M]    = 1'b0;
        clear_s[STAGE_W]    = 1'b0;
    end

    for (genvar s = 0; s < 4; s++) begin : g_stage
        pipe_track_stage u_stage (
            .clk        (clk),
            .rst        (rst),
            .clear_s    (clear_s[s]),
            .load_s     (load_s[s]),
            .entry_in_s (stage_in_s[s]),
            .entry_r    (stage_r[s])
        );
    end

    // Pending-flush flag: set while frozen, consumed by the first free edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend_r <= 1'b0;
        end else if (freeze) begin
            flush_pend_r <= flush_pend_r | flush;
        end else begin
            flush_pend_r <= 1'b0;
        end
    end

    // Sticky halted flag, set on the edge after a HALT sits in W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_r <= 1'b0;
        end else if (entry_is_halt(stage_r[STAGE_W])) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Busy decode: OR of pending writes, so duplicates stay busy until the last leaves.
    always_comb begin
        busy_s = write_onehot(stage_r[STAGE_D]) |
                 write_onehot(stage_r[STAGE_X]) |
                 write_onehot(stage_r[STAGE_M]);
        if (BUSY_INCL_W != 0) begin
            busy_s = busy_s | write_onehot(stage_r[STAGE_W]);
        end else begin
            busy_s = busy_s;
        end
    end

    // Popcount of valid entries across D..W.
    always_comb begin
        inflight_s = {2'b00, stage_r[STAGE_D].valid} +
                     {2'b00, stage_r[STAGE_X].valid} +
                     {2'b00, stage_r[STAGE_M].valid} +
                     {2'b00, stage_r[STAGE_W].valid};
    end

    assign regWrtD     = stage_r[STAGE_D].valid & stage_r[STAGE_D].regwrt;
    assign regWrtX     = stage_r[STAGE_X].valid & stage_r[STAGE_X].regwrt;
    assign regWrtM     = stage_r[STAGE_M].valid & stage_r[STAGE_M].regwrt;
    assign regWrtW     = stage_r[STAGE_W].valid & stage_r[STAGE_W].regwrt;
    assign wrtRegD     = stage_r[STAGE_D].wrtreg;
    assign wrtRegX     = stage_r[STAGE_X].wrtreg;
    assign wrtRegM     = stage_r[STAGE_M].wrtreg;
    assign wrtRegW     = stage_r[STAGE_W].wrtreg;
    assign branchInstD = stage_r[STAGE_D].valid & stage_r[STAGE_D].branch;
    assign branchInstX = stage_r[STAGE_X].valid & stage_r[STAGE_X].branch;
    assign branchInstM = stage_r[STAGE_M].valid & stage_r[STAGE_M].branch;
    assign branchInstW = stage_r[STAGE_W].valid & stage_r[STAGE_W].branch;
    assign busy_mask   = busy_s;
    assign inflight    = inflight_s;
    assign halted      = halted_r;

endmodule
